// File: rtl/ff_net_pkg.sv
// ---------------------------------------------------------------------------
// ff_net_pkg : FSM state encoding and address map shared by ff_network users
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ff_net_pkg;

    localparam int LENGHT_I_DEF   = 32;
    localparam int LENGHT_MID_DEF = 8;
    localparam int LENGHT_O_DEF   = 2;

    function automatic int weight_words(input int li, input int lm, input int lo);
        return li * lm + lm * lo;
    endfunction

    // Default address map: weights, a gap word, inputs, a gap word, outputs.
    localparam int N_W    = weight_words(LENGHT_I_DEF, LENGHT_MID_DEF, LENGHT_O_DEF);
    localparam int I_BASE = N_W + 1;
    localparam int O_BASE = I_BASE + LENGHT_I_DEF + 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR_W = 3'd1,
        ST_WR_I = 3'd2,
        ST_WAIT = 3'd3,
        ST_RD   = 3'd4
    } host_state_e;

endpackage

`default_nettype wire

// File: rtl/ff_host_rd_buf.sv
// ---------------------------------------------------------------------------
// ff_host_rd_buf : one-entry result buffer behind an RD_LAT read delay line
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ff_host_rd_buf #(
    parameter int WIDTH  = 32,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue,
    input  logic [WIDTH-1:0] rdata,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic             empty
);

    logic [RD_LAT-1:0] r_pend;
    logic              r_valid;
    logic [WIDTH-1:0]  r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend  <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_pend <= (r_pend << 1) | RD_LAT'(issue);
            // Capture and drain never coincide: a read issues only when empty.
            if (r_pend[RD_LAT-1]) begin
                r_valid <= 1'b1;
                r_data  <= rdata;
            end else if (r_valid && m_ready) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end
        end
    end

    assign m_valid = r_valid;
    assign m_data  = r_data;
    assign empty   = !r_valid && (r_pend == '0);

endmodule

`default_nettype wire

// File: rtl/ff_network_host.sv
// ---------------------------------------------------------------------------
// ff_network_host : bus master that loads ff_network and streams its results
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ff_network_host
    import ff_net_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int LENGHT_I   = LENGHT_I_DEF,
    parameter int LENGHT_MID = LENGHT_MID_DEF,
    parameter int LENGHT_O   = LENGHT_O_DEF,
    parameter int RD_LAT     = 1,
    parameter int TIMEOUT    = 4096,
    parameter int WIDTH_ADDR = $clog2(weight_words(LENGHT_I, LENGHT_MID, LENGHT_O)
                                      + LENGHT_I + LENGHT_O + 3)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  load_w,
    input  logic                  s_valid,
    input  logic [WIDTH-1:0]      s_data,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [WIDTH-1:0]      m_data,
    input  logic                  m_ready,
    output logic                  read,
    output logic                  write,
    output logic [WIDTH_ADDR-1:0] address,
    output logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH-1:0]      rdata,
    input  logic                  net_ready,
    input  logic                  net_down,
    output logic                  busy,
    output logic                  timeout
);

    localparam int c_n_w    = weight_words(LENGHT_I, LENGHT_MID, LENGHT_O);
    localparam int c_i_base = c_n_w + 1;
    localparam int c_o_base = c_i_base + LENGHT_I + 1;
    localparam int IDX_W    = $clog2(c_n_w + 1);
    localparam int WCNT_W   = $clog2(TIMEOUT + 1);

    host_state_e       r_state;
    host_state_e       w_next;
    logic [IDX_W-1:0]  r_idx;
    logic [WCNT_W-1:0] r_wait;
    logic              r_timeout;
    logic              w_wr_hs;
    logic              w_rd_issue;
    logic              w_rd_empty;
    logic              w_m_hs;
    logic              w_idx_inc;
    logic              w_idx_clr;
    logic              w_set_tmo;

    // Strobes are gated by reset so an abort takes effect in the same cycle.
    assign s_ready    = ((r_state == ST_WR_W) || (r_state == ST_WR_I)) && net_ready && !reset;
    assign w_wr_hs    = s_ready && s_valid;
    assign w_rd_issue = (r_state == ST_RD) && net_ready && w_rd_empty && !reset;
    assign w_m_hs     = m_valid && m_ready;

    assign write   = w_wr_hs;
    assign read    = w_rd_issue;
    assign wdata   = w_wr_hs ? s_data : '0;
    assign busy    = (r_state != ST_IDLE);
    assign timeout = r_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_idx_inc = 1'b0;
        w_idx_clr = 1'b0;
        w_set_tmo = 1'b0;
        address   = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next    = load_w ? ST_WR_W : ST_WR_I;
                    w_idx_clr = 1'b1;
                end
            end
            ST_WR_W: begin
                address = WIDTH_ADDR'(r_idx);
                if (w_wr_hs) begin
                    if (r_idx == IDX_W'(c_n_w - 1)) begin
                        w_next    = ST_WR_I;
                        w_idx_clr = 1'b1;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end
            end
            ST_WR_I: begin
                address = WIDTH_ADDR'(c_i_base) + WIDTH_ADDR'(r_idx);
                if (w_wr_hs) begin
                    if (r_idx == IDX_W'(LENGHT_I - 1)) begin
                        w_next    = ST_WAIT;
                        w_idx_clr = 1'b1;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (net_down) begin
                    w_next = ST_RD;
                end else if (r_wait == WCNT_W'(TIMEOUT - 1)) begin
                    w_next    = ST_IDLE;
                    w_set_tmo = 1'b1;
                end
            end
            ST_RD: begin
                // In RD the index counts delivered results, so it doubles as k.
                address = WIDTH_ADDR'(c_o_base) + WIDTH_ADDR'(r_idx);
                if (w_m_hs) begin
                    if (r_idx == IDX_W'(LENGHT_O - 1)) begin
                        w_next    = ST_IDLE;
                        w_idx_clr = 1'b1;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx     <= '0;
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_idx_clr) begin
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + 1'b1;
            end
            r_wait <= (r_state == ST_WAIT) ? r_wait + 1'b1 : '0;
            if ((r_state == ST_IDLE) && start) begin
                r_timeout <= 1'b0;
            end else if (w_set_tmo) begin
                r_timeout <= 1'b1;
            end
        end
    end

    ff_host_rd_buf #(
        .WIDTH  (WIDTH),
        .RD_LAT (RD_LAT)
    ) u_rd_buf (
        .clk     (clk),
        .reset   (reset),
        .issue   (w_rd_issue),
        .rdata   (rdata),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .empty   (w_rd_empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_ff_network_host.sv
// ---------------------------------------------------------------------------
// tb_ff_network_host : scoreboard bench for ff_network_host
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ff_network_host;

    localparam int NW  = 32 * 8 + 8 * 2;
    localparam int IB  = NW + 1;
    localparam int OB  = IB + 32 + 1;
    localparam int LI  = 32;
    localparam int LO  = 2;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        reset, start, load_w, s_valid, m_ready, net_ready, net_down;
    logic [31:0] s_data;
    logic [31:0] rdata = '0;
    logic        s_ready, m_valid, read, write, busy, timeout;
    logic [31:0] m_data, wdata;
    logic [8:0]  address;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_wr = 0;
    int n_res = 0;
    int first_wr = 0;
    int last_wr = 0;
    int start_cyc = 0;
    bit nr_toggle = 1'b0;

    logic [40:0] wq[$];
    logic [31:0] rq[$];

    ff_network_host #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .load_w    (load_w),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .read      (read),
        .write     (write),
        .address   (address),
        .wdata     (wdata),
        .rdata     (rdata),
        .net_ready (net_ready),
        .net_down  (net_down),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Network slave model: read data appears one cycle after the strobe.
    always @(posedge clk) if (read) rdata <= 32'(address) + 32'd100;

    initial begin
        forever begin
            @(negedge clk);
            if (nr_toggle) net_ready = ~net_ready;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    always @(negedge clk) begin
        logic [40:0] e;
        #2;
        if (write) begin
            if (n_wr == 0) first_wr = cyc;
            last_wr = cyc;
            n_wr++;
            chk("wr_net_ready", 64'(net_ready), 64'd1);
            chk("wr_rd_excl", 64'(read), 64'd0);
            if (wq.size() == 0) chk("wr_extra", 64'(write), 64'd0);
            else begin
                e = wq.pop_front();
                chk("wr_addr", 64'(address), 64'(e[40:32]));
                chk("wr_data", 64'(wdata), 64'(e[31:0]));
            end
        end
        if (m_valid && m_ready) begin
            n_res++;
            if (rq.size() == 0) chk("res_extra", 64'(m_valid), 64'd0);
            else chk("res_data", 64'(m_data), 64'(rq.pop_front()));
        end
    end

    task automatic drive_job(input bit lw, input int abort_at, input bit push_res);
        int          n;
        int          waited;
        bit          hs;
        bit          dropped;
        logic [8:0]  a;
        logic [31:0] d;
        n = lw ? NW + LI : LI;
        if (push_res) for (int k = 0; k < LO; k++) rq.push_back(32'(OB + k + 100));
        start = 1'b1;
        load_w = lw;
        start_cyc = cyc;
        dropped = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = (lw && i < NW) ? 9'(i) : 9'(IB + i - (lw ? NW : 0));
            d = $urandom;
            s_valid = 1'b1;
            s_data = d;
            wq.push_back({a, d});
            waited = 0;
            forever begin
                #3;
                hs = s_ready;
                if (hs && (i + 1 == abort_at)) reset = 1'b1;
                @(negedge clk);
                if (!dropped) begin
                    dropped = 1'b1;
                    start = 1'b0;
                    load_w = 1'b0;
                    chk("busy_on_start", 64'(busy), 64'd1);
                    chk("timeout_cleared", 64'(timeout), 64'd0);
                end
                if (hs) break;
                waited++;
                if (waited > 2000) begin
                    chk("src_handshake", 64'd0, 64'd1);
                    s_valid = 1'b0;
                    return;
                end
            end
            if (i + 1 == abort_at) begin
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic run_tail(input bit hold);
        int target;
        int w;
        target = n_res + LO;
        m_ready = !hold;
        repeat (10) @(negedge clk);
        net_down = 1'b1;
        @(negedge clk);
        net_down = 1'b0;
        if (hold) begin
            w = 0;
            while (!m_valid && w < 200) begin
                @(negedge clk);
                w++;
            end
            chk("hold_seen", 64'(m_valid), 64'd1);
            for (int i = 0; i < 5; i++) begin
                chk("hold_valid", 64'(m_valid), 64'd1);
                chk("hold_data", 64'(m_data), 64'(OB + 100));
                @(negedge clk);
            end
            m_ready = 1'b1;
        end
        w = 0;
        while ((n_res < target || busy) && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("res_count", 64'(n_res), 64'(target));
        chk("idle_after_job", 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; load_w = 1'b0; s_valid = 1'b0; s_data = '0;
        m_ready = 1'b1; net_ready = 1'b1; net_down = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_read", 64'(read), 64'd0);
        chk("rst_write", 64'(write), 64'd0);
        chk("rst_address", 64'(address), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_no_start", 64'(busy), 64'd0);

        // Weights plus inputs, continuous source.
        n_wr = 0;
        drive_job(1'b1, -1, 1'b1);
        chk("job1_writes", 64'(n_wr), 64'(NW + LI));
        chk("job1_no_gaps", 64'(last_wr - first_wr), 64'(NW + LI - 1));
        chk("job1_latency", 64'(first_wr), 64'(start_cyc + 1));
        run_tail(1'b0);

        // Inputs only, net_ready toggling, stray start mid-job.
        n_wr = 0;
        nr_toggle = 1'b1;
        fork
            begin
                repeat (20) @(negedge clk);
                start = 1'b1; load_w = 1'b1;
                @(negedge clk);
                start = 1'b0; load_w = 1'b0;
            end
        join_none
        drive_job(1'b0, -1, 1'b1);
        nr_toggle = 1'b0;
        net_ready = 1'b1;
        chk("job2_writes", 64'(n_wr), 64'(LI));
        run_tail(1'b1);

        // No net_down: expect timeout TMO cycles into WAIT.
        drive_job(1'b0, -1, 1'b0);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (timeout) begin
                n = i;
                break;
            end
        end
        chk("timeout_cycles", 64'(n), 64'(TMO));
        chk("timeout_idle", 64'(busy), 64'd0);
        @(negedge clk);
        chk("timeout_sticky", 64'(timeout), 64'd1);
        drive_job(1'b0, -1, 1'b1);
        run_tail(1'b0);

        // Reset during the 100th weight write.
        n_wr = 0;
        drive_job(1'b1, 100, 1'b0);
        chk("abort_count", 64'(n_wr), 64'd100);
        chk("abort_write", 64'(write), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        wq.delete();
        @(negedge clk);
        n_wr = 0;
        drive_job(1'b1, -1, 1'b1);
        chk("job6_writes", 64'(n_wr), 64'(NW + LI));
        run_tail(1'b0);

        chk("wq_drained", 64'(wq.size()), 64'd0);
        chk("rq_drained", 64'(rq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got %0d checks, expected run to finish", n_chk);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
